// File: rtl/fifo_wr_arbiter.sv
// Shares the TX FIFO write port between the ALU result path (2 bytes, low first) and the register read path (1 byte).
// Define FIFO_WR_ARB_STATS_EN to build the saturating wfull stall counter; otherwise stall_cnt is tied to zero.
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_IDLE   | no transfer; arbitrate alu_req / reg_req
// ST_ALU_LO | writing ALU result low byte (alu_ack high on entry)
// ST_ALU_HI | writing ALU result high byte
// ST_REG    | writing register byte (reg_ack high on entry)
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    w_clk,
    input  logic                    w_rst,
    input  logic                    alu_req,
    input  logic [2*DATA_WIDTH-1:0] alu_data,
    output logic                    alu_ack,
    input  logic                    reg_req,
    input  logic [DATA_WIDTH-1:0]   reg_data,
    output logic                    reg_ack,
    input  logic                    wfull,
    output logic                    w_inc,
    output logic [DATA_WIDTH-1:0]   w_data,
    output logic                    busy,
    output logic [15:0]             stall_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ALU_LO = 2'd1,
        ST_ALU_HI = 2'd2,
        ST_REG    = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_d;
    logic                    last_grant_alu;
    logic                    last_grant_alu_d;
    logic                    grant_alu;
    logic                    grant_reg;
    logic [2*DATA_WIDTH-1:0] data_q;
    logic [2*DATA_WIDTH-1:0] data_d;

    assign busy  = (state != ST_IDLE);
    assign w_inc = !w_rst && busy && !wfull;

    always_comb begin
        w_data = '0;
        case (state)
            ST_ALU_LO: w_data = data_q[DATA_WIDTH-1:0];
            ST_ALU_HI: w_data = data_q[2*DATA_WIDTH-1:DATA_WIDTH];
            ST_REG:    w_data = data_q[DATA_WIDTH-1:0];
            default:   w_data = '0;
        endcase
    end

    // last_grant only moves on a tie, so a lone request does not steal the next tie
    always_comb begin
        state_d          = state;
        last_grant_alu_d = last_grant_alu;
        grant_alu        = 1'b0;
        grant_reg        = 1'b0;
        data_d           = data_q;
        case (state)
            ST_IDLE: begin
                if (alu_req && (!reg_req || !last_grant_alu)) begin
                    grant_alu = 1'b1;
                    state_d   = ST_ALU_LO;
                    data_d    = alu_data;
                    if (reg_req) last_grant_alu_d = 1'b1;
                end else if (reg_req) begin
                    grant_reg = 1'b1;
                    state_d   = ST_REG;
                    data_d    = {{DATA_WIDTH{1'b0}}, reg_data};
                    if (alu_req) last_grant_alu_d = 1'b0;
                end
            end
            ST_ALU_LO: if (w_inc) state_d = ST_ALU_HI;
            ST_ALU_HI: if (w_inc) state_d = ST_IDLE;
            ST_REG:    if (w_inc) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state          <= ST_IDLE;
            last_grant_alu <= 1'b0;
            data_q         <= '0;
            alu_ack        <= 1'b0;
            reg_ack        <= 1'b0;
        end else begin
            state          <= state_d;
            last_grant_alu <= last_grant_alu_d;
            data_q         <= data_d;
            alu_ack        <= grant_alu;
            reg_ack        <= grant_reg;
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            stall_q <= '0;
        end else if (busy && wfull && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed cycle table, randomized traffic against a byte-queue model, stall counter hold.
module tb_fifo_wr_arbiter;

`ifdef FIFO_WR_ARB_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        w_clk;
    logic        w_rst;
    logic        alu_req;
    logic [15:0] alu_data;
    logic        alu_ack;
    logic        reg_req;
    logic [7:0]  reg_data;
    logic        reg_ack;
    logic        wfull;
    logic        w_inc;
    logic [7:0]  w_data;
    logic        busy;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_wr_arbiter #(.DATA_WIDTH(8)) dut (
        .w_clk     (w_clk),
        .w_rst     (w_rst),
        .alu_req   (alu_req),
        .alu_data  (alu_data),
        .alu_ack   (alu_ack),
        .reg_req   (reg_req),
        .reg_data  (reg_data),
        .reg_ack   (reg_ack),
        .wfull     (wfull),
        .w_inc     (w_inc),
        .w_data    (w_data),
        .busy      (busy),
        .stall_cnt (stall_cnt)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        areq;
        logic [15:0] adata;
        logic        rreq;
        logic [7:0]  rdata;
        logic        full;
        logic        e_inc;
        logic [7:0]  e_data;
        logic        e_aack;
        logic        e_rack;
        logic        e_busy;
        logic [15:0] e_stall;
    } vec_t;

    function automatic vec_t v(input logic rst, input logic areq, input logic [15:0] adata,
                               input logic rreq, input logic [7:0] rdata, input logic full,
                               input logic e_inc, input logic [7:0] e_data, input logic e_aack,
                               input logic e_rack, input logic e_busy, input int stall);
        vec_t r;
        r.rst = rst;  r.areq = areq; r.adata = adata; r.rreq = rreq; r.rdata = rdata; r.full = full;
        r.e_inc = e_inc; r.e_data = e_data; r.e_aack = e_aack; r.e_rack = e_rack; r.e_busy = e_busy;
        r.e_stall = 16'(stall * STATS);
        return r;
    endfunction

    // reference model state for random traffic
    logic [7:0] q[$];
    logic       m_last_alu;
    logic       exp_ack;
    logic       alu_seen;
    logic       reg_seen;
    int         m_stall;

    task automatic random_cycle(input bit allow_new);
        logic p_alu, p_reg, win_alu, idle_now, exp_inc;
        @(negedge w_clk);
        p_alu = alu_req;
        p_reg = reg_req;
        if (alu_seen) alu_req = 1'b0;
        else if (allow_new && !alu_req && $urandom_range(2) == 0) begin
            alu_req  = 1'b1;
            alu_data = 16'($urandom);
        end
        if (reg_seen) reg_req = 1'b0;
        else if (allow_new && !reg_req && $urandom_range(2) == 0) begin
            reg_req  = 1'b1;
            reg_data = 8'($urandom);
        end
        wfull = allow_new ? ($urandom_range(2) == 0) : 1'b0;
        #1;
        check("rnd_ack_due", {31'd0, alu_ack | reg_ack}, {31'd0, exp_ack});
        check("rnd_ack_excl", {31'd0, alu_ack & reg_ack}, 32'd0);
        if (alu_ack || reg_ack) begin
            win_alu = (p_alu && p_reg) ? !m_last_alu : p_alu;
            if (p_alu && p_reg) m_last_alu = win_alu;
            check("rnd_grant_alu", {31'd0, alu_ack}, {31'd0, win_alu});
            if (win_alu) begin
                q.push_back(alu_data[7:0]);
                q.push_back(alu_data[15:8]);
            end else begin
                q.push_back(reg_data);
            end
        end
        idle_now = (q.size() == 0);
        exp_inc  = !idle_now && !wfull;
        check("rnd_busy", {31'd0, busy}, {31'd0, !idle_now});
        check("rnd_w_inc", {31'd0, w_inc}, {31'd0, exp_inc});
        if (!idle_now) check("rnd_w_data", {24'd0, w_data}, {24'd0, q[0]});
        check("rnd_stall", {16'd0, stall_cnt}, m_stall);
        if (exp_inc) void'(q.pop_front());
        if (STATS == 1 && !idle_now && wfull && m_stall != 16'hFFFF) m_stall++;
        exp_ack  = idle_now && (alu_req || reg_req);
        alu_seen = alu_ack;
        reg_seen = reg_ack;
    endtask

    vec_t vecs[29];
    int   hold;

    initial begin
        w_rst = 1'b1; alu_req = 1'b1; alu_data = 16'hA55A; reg_req = 1'b0; reg_data = 8'h00; wfull = 1'b0;

        //            rst areq adata     rreq rdata full | inc data  aack rack busy stall
        vecs[0]  = v(1, 1, 16'hA55A, 0, 8'h00, 0,   0, 8'h00, 0, 0, 0, 0);
        vecs[1]  = v(1, 1, 16'hA55A, 0, 8'h00, 0,   0, 8'h00, 0, 0, 0, 0);
        vecs[2]  = v(0, 0, 16'h0000, 0, 8'h00, 0,   0, 8'h00, 0, 0, 0, 0);
        vecs[3]  = v(0, 1, 16'hA55A, 0, 8'h00, 0,   0, 8'h00, 0, 0, 0, 0);
        vecs[4]  = v(0, 1, 16'hA55A, 0, 8'h00, 0,   1, 8'h5A, 1, 0, 1, 0);
        vecs[5]  = v(0, 0, 16'h0000, 0, 8'h00, 0,   1, 8'hA5, 0, 0, 1, 0);
        vecs[6]  = v(0, 0, 16'h0000, 0, 8'h00, 0,   0, 8'h00, 0, 0, 0, 0);
        vecs[7]  = v(0, 1, 16'h1234, 1, 8'h77, 0,   0, 8'h00, 0, 0, 0, 0);
        vecs[8]  = v(0, 1, 16'h1234, 1, 8'h77, 0,   1, 8'h34, 1, 0, 1, 0);
        vecs[9]  = v(0, 0, 16'h0000, 1, 8'h77, 0,   1, 8'h12, 0, 0, 1, 0);
        vecs[10] = v(0, 0, 16'h0000, 1, 8'h77, 0,   0, 8'h00, 0, 0, 0, 0);
        vecs[11] = v(0, 0, 16'h0000, 1, 8'h77, 0,   1, 8'h77, 0, 1, 1, 0);
        vecs[12] = v(0, 1, 16'h5566, 1, 8'h3C, 0,   0, 8'h00, 0, 0, 0, 0);
        vecs[13] = v(0, 1, 16'h5566, 1, 8'h3C, 0,   1, 8'h3C, 0, 1, 1, 0);
        vecs[14] = v(0, 1, 16'h5566, 0, 8'h00, 0,   0, 8'h00, 0, 0, 0, 0);
        vecs[15] = v(0, 1, 16'h5566, 0, 8'h00, 0,   1, 8'h66, 1, 0, 1, 0);
        vecs[16] = v(0, 0, 16'h0000, 0, 8'h00, 0,   1, 8'h55, 0, 0, 1, 0);
        vecs[17] = v(0, 0, 16'h0000, 0, 8'h00, 0,   0, 8'h00, 0, 0, 0, 0);
        vecs[18] = v(0, 1, 16'hBEEF, 0, 8'h00, 0,   0, 8'h00, 0, 0, 0, 0);
        vecs[19] = v(0, 1, 16'hBEEF, 0, 8'h00, 0,   1, 8'hEF, 1, 0, 1, 0);
        vecs[20] = v(0, 0, 16'h0000, 0, 8'h00, 1,   0, 8'hBE, 0, 0, 1, 0);
        vecs[21] = v(0, 0, 16'h0000, 0, 8'h00, 1,   0, 8'hBE, 0, 0, 1, 1);
        vecs[22] = v(0, 0, 16'h0000, 0, 8'h00, 1,   0, 8'hBE, 0, 0, 1, 2);
        vecs[23] = v(0, 0, 16'h0000, 0, 8'h00, 0,   1, 8'hBE, 0, 0, 1, 3);
        vecs[24] = v(0, 0, 16'h0000, 0, 8'h00, 0,   0, 8'h00, 0, 0, 0, 3);
        vecs[25] = v(0, 1, 16'hC0DE, 0, 8'h00, 0,   0, 8'h00, 0, 0, 0, 3);
        vecs[26] = v(0, 1, 16'hC0DE, 0, 8'h00, 0,   1, 8'hDE, 1, 0, 1, 3);
        vecs[27] = v(1, 0, 16'h0000, 0, 8'h00, 0,   0, 8'hC0, 0, 0, 1, 3);
        vecs[28] = v(0, 0, 16'h0000, 0, 8'h00, 0,   0, 8'h00, 0, 0, 0, 0);

        for (int i = 0; i < 29; i++) begin
            @(negedge w_clk);
            w_rst = vecs[i].rst; alu_req = vecs[i].areq; alu_data = vecs[i].adata;
            reg_req = vecs[i].rreq; reg_data = vecs[i].rdata; wfull = vecs[i].full;
            #1;
            check($sformatf("vec%0d_w_inc", i),   {31'd0, w_inc},     {31'd0, vecs[i].e_inc});
            check($sformatf("vec%0d_w_data", i),  {24'd0, w_data},    {24'd0, vecs[i].e_data});
            check($sformatf("vec%0d_alu_ack", i), {31'd0, alu_ack},   {31'd0, vecs[i].e_aack});
            check($sformatf("vec%0d_reg_ack", i), {31'd0, reg_ack},   {31'd0, vecs[i].e_rack});
            check($sformatf("vec%0d_busy", i),    {31'd0, busy},      {31'd0, vecs[i].e_busy});
            check($sformatf("vec%0d_stall", i),   {16'd0, stall_cnt}, {16'd0, vecs[i].e_stall});
        end

        // random traffic from a clean post-reset idle state
        m_last_alu = 1'b0;
        exp_ack    = 1'b0;
        alu_seen   = 1'b0;
        reg_seen   = 1'b0;
        m_stall    = 0;
        for (int c = 0; c < 3000; c++) random_cycle(1'b1);
        for (int c = 0; c < 20; c++) random_cycle(1'b0);
        check("rnd_drained", q.size(), 32'd0);

        // long wfull hold inside REG, then release
        @(negedge w_clk);
        w_rst = 1'b1; alu_req = 1'b0; reg_req = 1'b0; wfull = 1'b0;
        @(negedge w_clk);
        w_rst = 1'b0; reg_req = 1'b1; reg_data = 8'h9A;
        @(negedge w_clk);
        reg_req = 1'b0; wfull = 1'b1;
        #1;
        check("sat_reg_ack", {31'd0, reg_ack}, 32'd1);
        check("sat_w_inc_held", {31'd0, w_inc}, 32'd0);
        hold = (STATS == 1) ? 70000 : 20;
        repeat (hold) @(negedge w_clk);
        #1;
        check("sat_stall", {16'd0, stall_cnt}, (STATS == 1) ? 32'h0000FFFF : 32'd0);
        check("sat_busy", {31'd0, busy}, 32'd1);
        check("sat_data_held", {24'd0, w_data}, 32'h9A);
        @(negedge w_clk);
        #1;
        check("sat_stall_stays", {16'd0, stall_cnt}, (STATS == 1) ? 32'h0000FFFF : 32'd0);
        @(negedge w_clk);
        wfull = 1'b0;
        #1;
        check("sat_release_w_inc", {31'd0, w_inc}, 32'd1);
        check("sat_release_data", {24'd0, w_data}, 32'h9A);
        @(negedge w_clk);
        #1;
        check("sat_done_w_inc", {31'd0, w_inc}, 32'd0);
        check("sat_done_busy", {31'd0, busy}, 32'd0);
        check("sat_stall_final", {16'd0, stall_cnt}, (STATS == 1) ? 32'h0000FFFF : 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Sequences and shares the TX async-FIFO write port between two requesters: the ALU result path (2-byte result) and the register-file read path (1 byte).
- Latches the granted request and serializes the ALU result low byte first. Drives w_inc/w_data into the FIFO write side, throttled by its wfull flag.
- Sits in the system-clock domain between the system controller datapath and the FIFO write-pointer logic.

Parameters:
- DATA_WIDTH, 8, FIFO word width; ALU result width is 2*DATA_WIDTH.

Ports:
- w_clk  in  1  system clock; all logic on rising edge.
- w_rst  in  1  synchronous, active-high reset.
- alu_req  in  1  ALU result pending; held until alu_ack.
- alu_data  in  2*DATA_WIDTH  ALU result; valid while alu_req is high.
- alu_ack  out  1  one-cycle pulse: ALU request accepted and data latched.
- reg_req  in  1  register read data pending; held until reg_ack.
- reg_data  in  DATA_WIDTH  register read data.
- reg_ack  out  1  one-cycle pulse: register request accepted.
- wfull  in  1  FIFO full flag from the write-side pointer logic.
- w_inc  out  1  FIFO write strobe; a word is written on each edge where it is high.
- w_data  out  DATA_WIDTH  FIFO write data.
- busy  out  1  high in any state other than IDLE.
- stall_cnt  out  16  wfull stall counter (see Optional Feature).

Behaviour:
- Reset is synchronous and active-high. In a cycle where w_rst=1: state<=IDLE, last_grant<=REG, data latch<=0, alu_ack/reg_ack<=0, stall_cnt<=0. While w_rst=1, w_inc is forced to 0 combinationally. An abort mid-transfer drops any unwritten byte.
- FSM states: IDLE, ALU_LO, ALU_HI, REG.
- IDLE:
  - Only alu_req=1 -> latch alu_data, pulse alu_ack next cycle, go to ALU_LO.
  - Only reg_req=1 -> latch reg_data, pulse reg_ack, go to REG.
  - Both high -> round-robin: grant the requester opposite last_grant, then update last_grant. The first tie after reset goes to ALU.
  - Neither high -> stay in IDLE.
- Ack timing: the ack is registered and is high exactly during the first cycle of the granted write state. The requester must deassert its req on the edge following ack. The FSM never samples req again earlier than one cycle after the ack cycle.
- w_data (combinational from the latch): ALU_LO -> latch[DATA_WIDTH-1:0]; ALU_HI -> latch[2*DATA_WIDTH-1:DATA_WIDTH]; REG -> latch[DATA_WIDTH-1:0]; IDLE -> 0.
- w_inc = !w_rst && (state in {ALU_LO, ALU_HI, REG}) && !wfull. It is combinational so the FIFO increments on the same edge the arbiter advances.
- Transitions:
  - ALU_LO -> ALU_HI when w_inc=1.
  - ALU_HI -> IDLE when w_inc=1.
  - REG -> IDLE when w_inc=1.
  - wfull=1 holds the current state and w_data indefinitely.
- Latency, empty FIFO: req sampled at edge N; ack and first w_inc in cycle N+1. ALU transfer completes in 2 cycles, REG in 1. busy drops in cycle N+3 (ALU) or N+2 (REG).
- Back-to-back: the earliest re-grant is from IDLE, one cycle after the final write. There is no pipelined overlap of grants.
- wfull toggling between the ALU bytes inserts wait cycles only. Bytes are never reordered, duplicated or skipped.
- No requester is ever acked without all of its bytes eventually written once wfull clears, unless reset intervenes.

Optional Feature:
- Macro: FIFO_WR_ARB_STATS_EN.
- Defined: stall_cnt increments by 1 each cycle where state≠IDLE and wfull=1. It saturates at 16'hFFFF and clears only on w_rst.
- Undefined: stall_cnt is tied to 16'h0000 and no counter logic is generated. All other behaviour is identical.

Test Plan:
- Reset: w_rst=1 for 2 cycles with alu_req=1 and wfull=0 -> w_inc=0, alu_ack=0, busy=0, stall_cnt=0 throughout.
- ALU single transfer: alu_data=16'hA55A, wfull=0 -> alu_ack pulse in cycle N+1; w_inc high in cycles N+1 and N+2 with w_data 8'h5A then 8'hA5; busy=0 in cycle N+3.
- Tie arbitration: alu_req and reg_req both high after reset (alu=16'h1234, reg=8'h77), each req held until its own ack -> ALU granted first (writes 34, 12); then reg granted (writes 77). With reg pending again plus a new ALU request, REG wins the next tie.
- Backpressure mid-ALU: alu_data=16'hBEEF, wfull=1 for 3 cycles after the EF byte is written -> state stays ALU_HI, w_inc=0, w_data=8'hBE held; BE written on the first cycle with wfull=0; stall_cnt=3 with FIFO_WR_ARB_STATS_EN, 0 without.
- Reset mid-transfer: w_rst=1 in the ALU_HI cycle -> w_inc=0 that cycle, next cycle IDLE with busy=0, high byte never written.
- Saturation (macro defined): hold wfull=1 in REG for 70000 cycles -> stall_cnt=16'hFFFF and stays there; drop wfull -> 1 write, counter unchanged.
